// File: rtl/uv_spi_txs_if.sv
// TX queue pop handshake between the SPI TX queue and the serializer.
// Queue side presents rdy/dat; serializer returns a one-cycle pop strobe.
interface uv_spi_txs_if #(
  parameter int DAT_WIDTH = 32
);
  logic                 txq_rdy;
  logic                 txq_vld;
  logic [DAT_WIDTH-1:0] txq_dat;

  modport master (
    output txq_rdy,
    output txq_dat,
    input  txq_vld
  );

  modport slave (
    input  txq_rdy,
    input  txq_dat,
    output txq_vld
  );
endinterface

// File: rtl/uv_spi_txs.sv
// SPI transmit serializer: pops one queue word per frame and drives
// SCK/MOSI/CS_N with programmable CPOL/CPHA, bit order, length and divider.
module uv_spi_txs #(
  parameter int DAT_WIDTH = 32,
  parameter int LEN_WIDTH = 6,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  uv_spi_txs_if.slave          txq,
  input  logic                 cfg_en,
  input  logic                 cfg_cpol,
  input  logic                 cfg_cpha,
  input  logic                 cfg_msb,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  output logic                 spi_sck,
  output logic                 spi_mosi,
  output logic                 spi_cs_n,
  output logic                 busy,
  output logic                 frm_done
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_e;

  localparam logic [LEN_WIDTH-1:0] LMAX = LEN_WIDTH'(DAT_WIDTH);
  localparam logic [LEN_WIDTH-1:0] ONE  = LEN_WIDTH'(1);

  state_e               st_q, st_d;
  logic [DIV_WIDTH-1:0] hp_q, hp_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [LEN_WIDTH-1:0] bit_q, bit_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [DAT_WIDTH-1:0] sh_q, sh_d;
  logic                 ph_q, ph_d;
  logic                 cpha_q, cpha_d;
  logic                 msb_q, msb_d;
  logic                 sck_q, sck_d;
  logic                 mosi_q, mosi_d;
  logic                 csn_q, csn_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [LEN_WIDTH-1:0] len_eff;
  logic [DAT_WIDTH-1:0] sh_ld;
  logic [DAT_WIDTH-1:0] sh_nx;
  logic                 head;
  logic                 hp_end;
  logic                 pop;

  assign pop     = (st_q == IDLE) && cfg_en && txq.txq_rdy && !rst;
  assign hp_end  = (hp_q == div_q);
  assign head    = msb_q ? sh_q[DAT_WIDTH-1] : sh_q[0];
  assign sh_nx   = msb_q ? (sh_q << 1) : (sh_q >> 1);
  assign len_eff = (cfg_len == '0 || cfg_len > LMAX) ? LMAX : cfg_len;
  // MSB-first frames are left-aligned so unused upper bits fall off the top
  assign sh_ld   = cfg_msb ? (txq.txq_dat << (LMAX - len_eff)) : txq.txq_dat;

  assign txq.txq_vld = pop;
  assign spi_sck     = sck_q;
  assign spi_mosi    = mosi_q;
  assign spi_cs_n    = csn_q;
  assign busy        = busy_q;
  assign frm_done    = done_q;

  // Next-state and registered-output logic for the frame sequencer
  always_comb begin
    st_d   = st_q;
    div_d  = div_q;
    bit_d  = bit_q;
    len_d  = len_q;
    sh_d   = sh_q;
    ph_d   = ph_q;
    cpha_d = cpha_q;
    msb_d  = msb_q;
    sck_d  = sck_q;
    mosi_d = mosi_q;
    csn_d  = csn_q;
    busy_d = busy_q;
    done_d = 1'b0;
    hp_d   = (st_q == IDLE || hp_end) ? '0 : hp_q + 1'b1;
    unique case (st_q)
      IDLE: begin
        sck_d  = cfg_cpol;
        csn_d  = 1'b1;
        busy_d = 1'b0;
        bit_d  = '0;
        ph_d   = 1'b0;
        if (pop) begin
          st_d   = SETUP;
          csn_d  = 1'b0;
          busy_d = 1'b1;
          div_d  = cfg_div;
          len_d  = len_eff;
          cpha_d = cfg_cpha;
          msb_d  = cfg_msb;
          sh_d   = sh_ld;
          if (!cfg_cpha) begin
            mosi_d = cfg_msb ? sh_ld[DAT_WIDTH-1] : sh_ld[0];
            sh_d   = cfg_msb ? (sh_ld << 1) : (sh_ld >> 1);
          end
        end
      end
      SETUP: begin
        if (hp_end) begin
          st_d  = SHIFT;
          sck_d = ~sck_q;
          ph_d  = 1'b1;
          if (cpha_q) begin
            mosi_d = head;
            sh_d   = sh_nx;
          end
        end
      end
      SHIFT: begin
        if (hp_end) begin
          if (ph_q) begin
            sck_d = ~sck_q;
            ph_d  = 1'b0;
            bit_d = bit_q + ONE;
            if (!cpha_q && bit_q != len_q - ONE) begin
              mosi_d = head;
              sh_d   = sh_nx;
            end
          end else if (bit_q == len_q) begin
            st_d = HOLD;
          end else begin
            sck_d = ~sck_q;
            ph_d  = 1'b1;
            if (cpha_q) begin
              mosi_d = head;
              sh_d   = sh_nx;
            end
          end
        end
      end
      HOLD: begin
        if (hp_end) begin
          st_d   = GAP;
          csn_d  = 1'b1;
          done_d = 1'b1;
        end
      end
      GAP: begin
        if (hp_end) begin
          st_d   = IDLE;
          busy_d = 1'b0;
        end
      end
      default: begin
        st_d = IDLE;
      end
    endcase
  end

  // State, counters, latched frame config and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      hp_q   <= '0;
      div_q  <= '0;
      bit_q  <= '0;
      len_q  <= '0;
      sh_q   <= '0;
      ph_q   <= 1'b0;
      cpha_q <= 1'b0;
      msb_q  <= 1'b0;
      sck_q  <= 1'b0;
      mosi_q <= 1'b0;
      csn_q  <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      hp_q   <= hp_d;
      div_q  <= div_d;
      bit_q  <= bit_d;
      len_q  <= len_d;
      sh_q   <= sh_d;
      ph_q   <= ph_d;
      cpha_q <= cpha_d;
      msb_q  <= msb_d;
      sck_q  <= sck_d;
      mosi_q <= mosi_d;
      csn_q  <= csn_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_uv_spi_txs.sv
// Directed bench for uv_spi_txs: queue model, edge monitor and
// hand-computed expectations for timing, bit order and framing.
module tb_uv_spi_txs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_en = 1'b0;
  logic        cfg_cpol = 1'b0;
  logic        cfg_cpha = 1'b0;
  logic        cfg_msb = 1'b1;
  logic [5:0]  cfg_len = 6'd8;
  logic [15:0] cfg_div = 16'd0;
  logic        spi_sck, spi_mosi, spi_cs_n, busy, frm_done;

  uv_spi_txs_if #(.DAT_WIDTH(32)) txq_if ();

  uv_spi_txs dut (
    .clk      (clk),
    .rst      (rst),
    .txq      (txq_if),
    .cfg_en   (cfg_en),
    .cfg_cpol (cfg_cpol),
    .cfg_cpha (cfg_cpha),
    .cfg_msb  (cfg_msb),
    .cfg_len  (cfg_len),
    .cfg_div  (cfg_div),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .spi_cs_n (spi_cs_n),
    .busy     (busy),
    .frm_done (frm_done)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] q[$];
  logic        pop_pend = 1'b0;
  int          cyc = 0;
  int          n_pop, n_done, n_edge, n_rise;
  int          pop_cyc, done_cyc, edge_cyc, rise0, rise_last;
  int          hi_run, min_gap;
  logic        sck_prev;
  logic        busy_seen, csn_low_seen;
  logic [63:0] rx;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    n_pop = 0; n_done = 0; n_edge = 0; n_rise = 0;
    pop_cyc = 0; done_cyc = 0; edge_cyc = 0; rise0 = 0; rise_last = 0;
    hi_run = 0; min_gap = 999; rx = '0;
    sck_prev = spi_sck;
    busy_seen = 1'b0; csn_low_seen = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target,
                           input int budget);
    for (int k = 0; k < budget && n_done < target; k++) tick();
    chk(tag, 64'(n_done), 64'(target));
  endtask

  // Queue model: retire the head one step after a sampled pop strobe
  always @(posedge clk) begin
    #1;
    if (pop_pend) begin
      if (q.size() > 0) void'(q.pop_front());
      pop_pend = 1'b0;
    end
    txq_if.txq_rdy = (q.size() != 0);
    if (q.size() != 0) txq_if.txq_dat = q[0];
    else txq_if.txq_dat = '0;
  end

  // Mid-cycle monitor of pops, frame ends, SCK edges and CS_N gaps
  always @(negedge clk) begin
    cyc++;
    if (txq_if.txq_vld === 1'b1) begin
      pop_pend = 1'b1;
      n_pop++;
      if (n_pop == 1) pop_cyc = cyc;
    end
    if (frm_done) begin
      n_done++;
      if (n_done == 1) done_cyc = cyc;
    end
    if (spi_sck != sck_prev) begin
      n_edge++;
      if (n_edge == 1) edge_cyc = cyc;
    end
    if (spi_sck && !sck_prev) begin
      n_rise++;
      rx = {rx[62:0], spi_mosi};
      if (n_rise == 1) rise0 = cyc;
      rise_last = cyc;
    end
    sck_prev = spi_sck;
    if (busy) busy_seen = 1'b1;
    if (!spi_cs_n) csn_low_seen = 1'b1;
    if (spi_cs_n) hi_run++;
    else begin
      if (hi_run > 0 && n_done > 0 && hi_run < min_gap) min_gap = hi_run;
      hi_run = 0;
    end
  end

  initial begin
    txq_if.txq_rdy = 1'b0;
    txq_if.txq_dat = '0;
    clr();
    repeat (3) tick();
    chk("rst_sck", 64'(spi_sck), 64'd0);
    chk("rst_mosi", 64'(spi_mosi), 64'd0);
    chk("rst_csn", 64'(spi_cs_n), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(frm_done), 64'd0);
    chk("rst_vld", 64'(txq_if.txq_vld), 64'd0);
    rst = 1'b0;
    tick();

    // 1: div0 CPOL0/CPHA0 MSB len8 0xA5
    cfg_div = 16'd0; cfg_cpol = 1'b0; cfg_cpha = 1'b0;
    cfg_msb = 1'b1; cfg_len = 6'd8;
    q.push_back(32'h0000_00A5);
    tick();
    clr();
    cfg_en = 1'b1;
    wait_done("t1_done", 1, 200);
    repeat (5) tick();
    chk("t1_pops", 64'(n_pop), 64'd1);
    chk("t1_dones", 64'(n_done), 64'd1);
    chk("t1_rises", 64'(n_rise), 64'd8);
    chk("t1_bits", rx & 64'hFF, 64'hA5);
    chk("t1_span", 64'(rise_last - rise0), 64'd14);
    chk("t1_edge", 64'(edge_cyc - pop_cyc), 64'd2);
    chk("t1_lat", 64'(done_cyc - pop_cyc), 64'd19);
    cfg_en = 1'b0;

    // 2: div3 CPOL1/CPHA1 LSB len32 0x1
    cfg_div = 16'd3; cfg_cpol = 1'b1; cfg_cpha = 1'b1;
    cfg_msb = 1'b0; cfg_len = 6'd32;
    repeat (3) tick();
    chk("t2_idle_sck", 64'(spi_sck), 64'd1);
    q.push_back(32'h0000_0001);
    tick();
    clr();
    cfg_en = 1'b1;
    wait_done("t2_done", 1, 600);
    repeat (3) tick();
    chk("t2_rises", 64'(n_rise), 64'd32);
    chk("t2_bits", rx & 64'hFFFF_FFFF, 64'h8000_0000);
    chk("t2_edge", 64'(edge_cyc - pop_cyc), 64'd5);
    chk("t2_lat", 64'(done_cyc - pop_cyc), 64'd265);
    chk("t2_end_sck", 64'(spi_sck), 64'd1);
    cfg_en = 1'b0;

    // 3: three queued words, len4, div1, upper bits hold junk
    cfg_div = 16'd1; cfg_cpol = 1'b0; cfg_cpha = 1'b0;
    cfg_msb = 1'b1; cfg_len = 6'd4;
    repeat (3) tick();
    q.push_back(32'hABCD_0003);
    q.push_back(32'h1234_567C);
    q.push_back(32'hFFFF_FFF9);
    tick();
    clr();
    cfg_en = 1'b1;
    wait_done("t3_done", 3, 400);
    repeat (10) tick();
    chk("t3_pops", 64'(n_pop), 64'd3);
    chk("t3_dones", 64'(n_done), 64'd3);
    chk("t3_rises", 64'(n_rise), 64'd12);
    chk("t3_bits", rx & 64'hFFF, 64'h3C9);
    chk("t3_gap", 64'(min_gap), 64'd3);
    cfg_en = 1'b0;

    // 4: disabled with data ready, then enabled with empty queue
    repeat (2) tick();
    q.push_back(32'h5555_5555);
    tick();
    clr();
    repeat (20) tick();
    chk("t4a_pops", 64'(n_pop), 64'd0);
    chk("t4a_busy", 64'(busy_seen), 64'd0);
    chk("t4a_csn", 64'(csn_low_seen), 64'd0);
    q.delete();
    repeat (2) tick();
    cfg_en = 1'b1;
    clr();
    repeat (20) tick();
    chk("t4b_pops", 64'(n_pop), 64'd0);
    chk("t4b_busy", 64'(busy_seen), 64'd0);
    chk("t4b_csn", 64'(csn_low_seen), 64'd0);

    // 5: reset after third SCK edge
    cfg_len = 6'd8; cfg_div = 16'd1;
    clr();
    q.push_back(32'h0000_00FF);
    for (int k = 0; k < 100 && n_edge < 3; k++) tick();
    chk("t5_edges", 64'(n_edge), 64'd3);
    rst = 1'b1;
    tick();
    chk("t5_sck", 64'(spi_sck), 64'd0);
    chk("t5_csn", 64'(spi_cs_n), 64'd1);
    chk("t5_mosi", 64'(spi_mosi), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    repeat (30) tick();
    chk("t5_dones", 64'(n_done), 64'd0);
    chk("t5_pops", 64'(n_pop), 64'd1);
    chk("t5_idle_csn", 64'(spi_cs_n), 64'd1);
    cfg_en = 1'b0;

    // 6: len=0 and len=33 both mean 32 bits
    cfg_div = 16'd0; cfg_len = 6'd0;
    repeat (2) tick();
    q.push_back(32'hFFFF_FFFF);
    tick();
    clr();
    cfg_en = 1'b1;
    wait_done("t6a_done", 1, 300);
    cfg_en = 1'b0;
    repeat (3) tick();
    chk("t6a_rises", 64'(n_rise), 64'd32);
    chk("t6a_bits", rx & 64'hFFFF_FFFF, 64'hFFFF_FFFF);
    chk("t6a_lat", 64'(done_cyc - pop_cyc), 64'd67);
    cfg_len = 6'd33;
    q.push_back(32'h8000_0001);
    tick();
    clr();
    cfg_en = 1'b1;
    wait_done("t6b_done", 1, 300);
    cfg_en = 1'b0;
    repeat (3) tick();
    chk("t6b_rises", 64'(n_rise), 64'd32);
    chk("t6b_bits", rx & 64'hFFFF_FFFF, 64'h8000_0001);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
